// File: rtl/attn_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | attn_pkg                                                              |
// | Shared types and helpers for the parametrised attention engine.       |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package attn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCORE = 3'd1,
        ST_NORM  = 3'd2,
        ST_OUT   = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam int QZ_XW = 64;

    function automatic int acc_w(input int n, input int d, input int w);
        return 2 * w + $clog2((n > d) ? n : d);
    endfunction

    function automatic int idx(input int i, input int k, input int d, input int w);
        return (i * d + k) * w;
    endfunction

    // Round half up by f fractional bits, then saturate to w bits; only the low xw bits of x count.
    function automatic logic [QZ_XW-1:0] qz(input logic [QZ_XW-1:0] x, input int xw,
                                            input int w, input int f);
        logic [QZ_XW-1:0] xv;
        logic [QZ_XW-1:0] half;
        logic [QZ_XW-1:0] r;
        logic [QZ_XW-1:0] mask;
        xv   = x & ({QZ_XW{1'b1}} >> (QZ_XW - xw));
        half = xv >> (f - 1);
        r    = (xv >> f) + {{(QZ_XW-1){1'b0}}, half[0]};
        mask = {QZ_XW{1'b1}} >> (QZ_XW - w);
        return ((r & ~mask) != '0) ? mask : r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/attn_mac_lane.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | attn_mac_lane                                                         |
// | Unsigned MAC lane with registered accumulator and rounded result.     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module attn_mac_lane
    import attn_pkg::*;
#(
    parameter int W     = 16,
    parameter int F     = 8,
    parameter int ACC_W = 35
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         acc_en_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] res_o
);

    logic [2*W-1:0]   prod;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    assign prod  = a_i * b_i;
    assign sum   = acc_q + ACC_W'(prod);
    // Result includes the current product so the final term lands in the same cycle.
    assign res_o = W'(qz(QZ_XW'(sum), ACC_W, W, F));

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (acc_en_i) begin
            acc_d = sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/attn_engine_param.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | attn_engine_param                                                     |
// | Single-head attention O = Norm(Q*K^T)*V on N shared MAC lanes.        |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module attn_engine_param
    import attn_pkg::*;
#(
    parameter int N = 8,
    parameter int D = 4,
    parameter int W = 16,
    parameter int F = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [N*D*W-1:0] q_in,
    input  logic [N*D*W-1:0] k_in,
    input  logic [N*D*W-1:0] v_in,
    output logic             busy,
    output logic             done,
    output logic [N*D*W-1:0] out
);

    localparam int ACC_W = acc_w(N, D, W);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int IW    = $clog2(N * D * W);
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(D - 1);
    localparam logic [CNT_W-1:0] LAST_N = CNT_W'(N - 1);

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   row_q;
    logic [CNT_W-1:0]   col_q;
    logic               mode_q;
    logic [N*D*W-1:0]   ql_q;
    logic [N*D*W-1:0]   kl_q;
    logic [N*D*W-1:0]   vl_q;
    logic               last_row;
    logic               enter_done;
    logic [IW-1:0]      q_base;
    logic [W-1:0]       p_row [N];

    assign last_row   = (row_q == LAST_N);
    assign enter_done = (state_q == ST_OUT) && (state_d == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign q_base     = IW'(idx(int'(row_q), int'(col_q), D, W));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SCORE;
            ST_SCORE: if (col_q == LAST_K && last_row) state_d = ST_NORM;
            ST_NORM:  if (last_row) state_d = ST_OUT;
            ST_OUT:   if (col_q == LAST_N && last_row) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q  <= '0;
            col_q  <= '0;
            mode_q <= 1'b0;
            ql_q   <= '0;
            kl_q   <= '0;
            vl_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    ql_q   <= q_in;
                    kl_q   <= k_in;
                    vl_q   <= v_in;
                    mode_q <= mode;
                    row_q  <= '0;
                    col_q  <= '0;
                end
                ST_SCORE: if (col_q == LAST_K) begin
                    col_q <= '0;
                    row_q <= last_row ? '0 : row_q + CNT_W'(1);
                end else begin
                    col_q <= col_q + CNT_W'(1);
                end
                ST_NORM: row_q <= last_row ? '0 : row_q + CNT_W'(1);
                ST_OUT: if (col_q == LAST_N) begin
                    col_q <= '0;
                    row_q <= last_row ? '0 : row_q + CNT_W'(1);
                end else begin
                    col_q <= col_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Lane j owns score column j; lanes below D also own output column j.
    for (genvar j = 0; j < N; j++) begin : g_lane
        logic [W-1:0]   a_op;
        logic [W-1:0]   b_op;
        logic           en;
        logic           clr;
        logic [W-1:0]   res;
        logic [IW-1:0]  k_base;
        logic [IW-1:0]  v_base;
        logic [W-1:0]   s_q [N];
        logic [W-1:0]   colmin_q;
        logic [W-1:0]   diff;
        logic [2*W-1:0] sq;
        logic [W-1:0]   norm_p;

        assign k_base = IW'(idx(j, int'(col_q), D, W));
        assign v_base = IW'(idx(int'(col_q), j, D, W));
        assign p_row[j] = s_q[row_q];

        always_comb begin
            a_op = '0;
            b_op = '0;
            en   = 1'b0;
            clr  = 1'b0;
            case (state_q)
                ST_IDLE: clr = 1'b1;
                ST_SCORE: begin
                    a_op = ql_q[q_base +: W];
                    b_op = kl_q[k_base +: W];
                    en   = 1'b1;
                    clr  = (col_q == LAST_K);
                end
                ST_OUT: if (j < D) begin
                    a_op = p_row[col_q];
                    b_op = vl_q[v_base +: W];
                    en   = 1'b1;
                    clr  = (col_q == LAST_N);
                end
                default: ;
            endcase
        end

        attn_mac_lane #(
            .W     (W),
            .F     (F),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .clr_i    (clr),
            .acc_en_i (en),
            .a_i      (a_op),
            .b_i      (b_op),
            .res_o    (res)
        );

        // Every stored score is at least its column minimum, so the difference never wraps.
        assign diff   = s_q[row_q] - colmin_q;
        assign sq     = diff * diff;
        assign norm_p = mode_q ? s_q[row_q] : W'(qz(QZ_XW'(sq), 2 * W, W, F));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s_q      <= '{default: '0};
                colmin_q <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: if (start) colmin_q <= '1;
                    ST_SCORE: if (col_q == LAST_K) begin
                        s_q[row_q] <= res;
                        if (res < colmin_q) colmin_q <= res;
                    end
                    ST_NORM: s_q[row_q] <= norm_p;
                    default: ;
                endcase
            end
        end

        if (j < D) begin : g_out
            logic [W-1:0] o_q   [N];
            logic [W-1:0] o_d   [N];
            logic [W-1:0] out_q [N];

            always_comb begin
                o_d = o_q;
                if (state_q == ST_OUT && col_q == LAST_N) o_d[row_q] = res;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    o_q   <= '{default: '0};
                    out_q <= '{default: '0};
                end else begin
                    o_q <= o_d;
                    if (enter_done) out_q <= o_d;
                end
            end

            for (genvar i = 0; i < N; i++) begin : g_row
                assign out[(i*D+j)*W +: W] = out_q[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_attn_engine_param.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_attn_engine_param                                                  |
// | Scoreboard bench: directed vectors plus reference-model runs.         |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_attn_engine_param;

    localparam int N   = 8;
    localparam int D   = 4;
    localparam int W   = 16;
    localparam int F   = 8;
    localparam int FW  = N * D * W;
    // Cycles from the first busy cycle to the done cycle.
    localparam int LAT = N * D + N + N * N;

    typedef struct {
        logic [FW-1:0] o;
        int            c;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          mode;
    logic [FW-1:0] q_in;
    logic [FW-1:0] k_in;
    logic [FW-1:0] v_in;
    logic          busy;
    logic          done;
    logic [FW-1:0] out;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t sb[$];

    attn_engine_param #(.N(N), .D(D), .W(W), .F(F)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .mode  (mode),
        .q_in  (q_in),
        .k_in  (k_in),
        .v_in  (v_in),
        .busy  (busy),
        .done  (done),
        .out   (out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    function automatic logic [FW-1:0] fill(input logic [W-1:0] val);
        logic [FW-1:0] r;
        for (int e = 0; e < N * D; e++) r[e*W +: W] = val;
        return r;
    endfunction

    function automatic longint unsigned mqz(input longint unsigned x);
        longint unsigned r;
        longint unsigned maxv;
        maxv = (64'd1 << W) - 64'd1;
        r = (x >> F) + ((x >> (F - 1)) & 64'd1);
        return (r > maxv) ? maxv : r;
    endfunction

    function automatic longint unsigned el(input logic [FW-1:0] v, input int i, input int k);
        return 64'(v[(i*D+k)*W +: W]);
    endfunction

    function automatic logic [FW-1:0] model(input logic [FW-1:0] q, input logic [FW-1:0] k,
                                            input logic [FW-1:0] v, input logic m);
        longint unsigned s [N][N];
        longint unsigned acc;
        longint unsigned cm;
        longint unsigned dlt;
        logic [FW-1:0]   o;
        o = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                acc = 0;
                for (int kk = 0; kk < D; kk++) acc += el(q, i, kk) * el(k, j, kk);
                s[i][j] = mqz(acc);
            end
        if (!m) begin
            for (int j = 0; j < N; j++) begin
                cm = s[0][j];
                for (int i = 1; i < N; i++) if (s[i][j] < cm) cm = s[i][j];
                for (int i = 0; i < N; i++) begin
                    dlt = s[i][j] - cm;
                    s[i][j] = mqz(dlt * dlt);
                end
            end
        end
        for (int i = 0; i < N; i++)
            for (int d = 0; d < D; d++) begin
                acc = 0;
                for (int j = 0; j < N; j++) acc += s[i][j] * el(v, j, d);
                o[(i*D+d)*W +: W] = W'(mqz(acc));
            end
        return o;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("spurious_done", FW'(done), FW'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out", out, e.o);
                check("done_cycle", FW'(cyc), FW'(e.c));
            end
        end
    end

    task automatic run_start(input logic [FW-1:0] q, input logic [FW-1:0] k,
                             input logic [FW-1:0] v, input logic m, input logic [FW-1:0] exp_o);
        exp_t e;
        @(negedge clk);
        q_in = q; k_in = k; v_in = v; mode = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        q_in = ~q; k_in = ~k; v_in = ~v; mode = ~m;
        check("busy_after_start", FW'(busy), FW'(1));
        e.o = exp_o;
        e.c = cyc + LAT;
        sb.push_back(e);
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int t = 0; t < 400 && !seen; t++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL done_timeout: no done within 400 cycles, required one pulse");
        end
    endtask

    initial begin
        logic [FW-1:0] q, k, v, exp_o;
        bit            seen;
        int            lim;

        rst_n = 1'b0; start = 1'b0; mode = 1'b0;
        q_in = '0; k_in = '0; v_in = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_busy", FW'(busy), FW'(0));
        check("reset_done", FW'(done), FW'(0));
        check("reset_out", out, '0);

        // Uniform bypass run; a second start mid-run and one in DONE must be ignored.
        run_start(fill(16'h0100), fill(16'h0100), fill(16'h0100), 1'b1, fill(16'h2000));
        repeat (8) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_mid_run", FW'(busy), FW'(1));
        wait_done(seen);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done_ignored", FW'(busy), FW'(0));

        // Constant columns in distance mode normalise to zero.
        run_start(fill(16'h0100), fill(16'h0100), fill(16'h0100), 1'b0, '0);
        wait_done(seen);

        // Round-half-up of a single tiny product.
        q = '0; k = '0; v = '0; exp_o = '0;
        q[W-1:0] = 16'h0001; k[W-1:0] = 16'h0080; v[W-1:0] = 16'h0100;
        exp_o[W-1:0] = 16'h0001;
        run_start(q, k, v, 1'b1, exp_o);
        wait_done(seen);

        // Scores and outputs both saturate.
        run_start(fill(16'h4000), fill(16'h4000), fill(16'h0100), 1'b1, fill(16'hFFFF));
        wait_done(seen);

        // Abort mid-run, then a clean restart.
        run_start(fill(16'h0100), fill(16'h0100), fill(16'h0100), 1'b1, fill(16'h2000));
        repeat (49) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", FW'(busy), FW'(0));
        check("abort_done", FW'(done), FW'(0));
        check("abort_out", out, '0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        run_start(fill(16'h0100), fill(16'h0100), fill(16'h0100), 1'b1, fill(16'h2000));
        wait_done(seen);

        // Row 1 scores 0x500 against column minimum 0x400: P = 0x100, out row 1 = 0x800.
        q = fill(16'h0100);
        q[(1*D+0)*W +: W] = 16'h0200;
        exp_o = '0;
        for (int d = 0; d < D; d++) exp_o[(1*D+d)*W +: W] = 16'h0800;
        run_start(q, fill(16'h0100), fill(16'h0100), 1'b0, exp_o);
        wait_done(seen);

        // Distance-mode runs against the reference model.
        for (int r = 0; r < 20; r++) begin
            lim = (r < 10) ? 'h00C0 : 'h01FF;
            for (int e = 0; e < N * D; e++) begin
                q[e*W +: W] = W'($urandom_range(0, lim));
                k[e*W +: W] = W'($urandom_range(0, lim));
                v[e*W +: W] = W'($urandom_range(0, lim));
            end
            run_start(q, k, v, 1'b0, model(q, k, v, 1'b0));
            wait_done(seen);
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
